spell_wb_master: RTL

- Wishbone initiator that drives the spell core's register window from a simple command/response interface.
- Used by the debug/loader path to upload state, single-step, and run programs.
- Performs single read or write transactions, plus a compound "run-and-wait" command.
  - Run-and-wait starts the core, polls REG_RUN until the core sleeps, then returns the final PC.
- Sits between a host-side controller (UART or LA bridge) and the spell slave port.

---
 rtl/spell_wb_master.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/spell_wb_master.sv
// Wishbone initiator for the spell core register window: single reads/writes from a
// command/response port, plus a run-and-wait sequence that polls REG_RUN and returns the final PC.
module spell_wb_master #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned POLL_INTERVAL  = 16
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [23:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic        abort,

  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic        busy,

  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_STROBE    = 3'd1;
  localparam logic [2:0] S_WAIT_ACK  = 3'd2;
  localparam logic [2:0] S_POLL_WAIT = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  localparam logic [1:0] PH_RUN_WRITE = 2'd0;
  localparam logic [1:0] PH_POLL      = 2'd1;
  localparam logic [1:0] PH_PC_READ   = 2'd2;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;

  localparam logic [23:0] REG_PC  = 24'h000;
  localparam logic [23:0] REG_RUN = 24'h00C;

  // Counters start at 0 on entry, so the last counted cycle is the interval minus one.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] POLL_LAST    = 16'(POLL_INTERVAL - 1);

  logic [2:0]  state;
  logic [1:0]  op_q;
  logic [1:0]  phase;
  logic [15:0] timeout_cnt;
  logic [15:0] poll_cnt;

  function automatic logic [31:0] bus_addr(input logic [23:0] offset);
    return BASE_ADDR | {8'b0, offset};
  endfunction

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // NOTE: all state below is sequential, so every assignment is non-blocking; a later
  // assignment to the same register in the same cycle simply overrides an earlier one.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= OP_READ;
      phase       <= PH_RUN_WRITE;
      timeout_cnt <= '0;
      poll_cnt    <= '0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_addr   <= '0;
      o_wb_data   <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_error   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q     <= cmd_op;
            o_wb_cyc <= 1'b1;
            o_wb_stb <= 1'b1;
            state    <= S_STROBE;
            if (cmd_op == OP_RUN) begin
              phase     <= PH_RUN_WRITE;
              o_wb_we   <= 1'b1;
              o_wb_addr <= bus_addr(REG_RUN);
              o_wb_data <= {30'b0, cmd_data[1], 1'b1};
            end else begin
              // Reserved op 3 falls through here as a plain read.
              o_wb_we   <= (cmd_op == OP_WRITE);
              o_wb_addr <= bus_addr(cmd_addr);
              o_wb_data <= cmd_data;
            end
          end
        end

        S_STROBE: begin
          // Single-cycle strobe: the slave acts on every stb&&cyc cycle.
          o_wb_stb    <= 1'b0;
          timeout_cnt <= '0;
          state       <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          if (i_wb_ack && o_wb_cyc) begin
            if (op_q == OP_RUN) begin
              case (phase)
                PH_RUN_WRITE: begin
                  o_wb_cyc <= 1'b0;
                  phase    <= PH_POLL;
                  poll_cnt <= '0;
                  state    <= S_POLL_WAIT;
                end
                PH_POLL: begin
                  if (i_wb_data[0]) begin
                    o_wb_cyc <= 1'b0;
                    poll_cnt <= '0;
                    state    <= S_POLL_WAIT;
                  end else begin
                    // Core is asleep: chain straight into the PC read.
                    phase     <= PH_PC_READ;
                    o_wb_stb  <= 1'b1;
                    o_wb_we   <= 1'b0;
                    o_wb_addr <= bus_addr(REG_PC);
                    o_wb_data <= '0;
                    state     <= S_STROBE;
                  end
                end
                default: begin
                  o_wb_cyc  <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_data  <= {24'b0, i_wb_data[7:0]};
                  rsp_error <= 1'b0;
                  state     <= S_RESP;
                end
              endcase
            end else begin
              o_wb_cyc  <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_data  <= (op_q == OP_WRITE) ? 32'h0 : i_wb_data;
              rsp_error <= 1'b0;
              state     <= S_RESP;
            end
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            o_wb_cyc  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_error <= 1'b1;
            state     <= S_RESP;
          end else begin
            timeout_cnt <= timeout_cnt + 16'd1;
          end
        end

        S_POLL_WAIT: begin
          // Abort is honoured only here, between bus cycles.
          if (abort) begin
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_error <= 1'b1;
            state     <= S_RESP;
          end else if (poll_cnt == POLL_LAST) begin
            o_wb_cyc  <= 1'b1;
            o_wb_stb  <= 1'b1;
            o_wb_we   <= 1'b0;
            o_wb_addr <= bus_addr(REG_RUN);
            o_wb_data <= '0;
            state     <= S_STROBE;
          end else begin
            poll_cnt <= poll_cnt + 16'd1;
          end
        end

        S_RESP: begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end

        default: begin
          o_wb_cyc  <= 1'b0;
          o_wb_stb  <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
